fifo_write_arbiter: RTL and testbench

Round-robin write-port arbiter in the `write_clk` domain of the asynchronous FIFO. It shares the single FIFO write port among `NREQ` independent producers. Grants are issued in bursts of up to `MAX_BURST` beats, and writes are throttled by the FIFO's `w_full` flag. The block sits directly in front of the FIFO write side, replacing a single fixed data source.

---
 rtl/fifo_write_arbiter.sv | 121 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NREQ producers, bursts of up to MAX_BURST beats.
// Define FIFO_ARB_PRIO0_EN to let requester 0 win every arbitration it takes part in.
module fifo_write_arbiter #(
    parameter int NREQ      = 4,
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              write_clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_data,
    input  logic              w_full,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   ack,
    output logic              wr_en,
    output logic [W-1:0]      wr_data,
    output logic              busy
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     gid_q, gid_d;
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]     beats_q, beats_d;
    logic [NREQ-1:0]   grant_q, grant_d;

    logic [2*NREQ-1:0] rot;
    logic [GW:0]       sum;
    logic [GW-1:0]     winner, next_ptr;
    logic              found, burst_end;

    // Rotate requests so bit 0 is the requester at rr_ptr, then take the first set bit.
    always_comb begin
        rot   = {req, req} >> rr_ptr_q;
        found = 1'b0;
        sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, rr_ptr_q} + (GW+1)'(k);
                if (sum >= (GW+1)'(NREQ))
                    sum = sum - (GW+1)'(NREQ);
            end
        end
        winner = sum[GW-1:0];
`ifdef FIFO_ARB_PRIO0_EN
        if (req[0]) begin
            found  = 1'b1;
            winner = '0;
        end
`endif
        next_ptr = (winner == GW'(NREQ-1)) ? '0 : winner + 1'b1;
    end

    always_ff @(posedge write_clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            gid_q    <= '0;
            rr_ptr_q <= '0;
            beats_q  <= '0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            gid_q    <= gid_d;
            rr_ptr_q <= rr_ptr_d;
            beats_q  <= beats_d;
            grant_q  <= grant_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gid_d    = gid_q;
        rr_ptr_d = rr_ptr_q;
        beats_d  = beats_q;
        grant_d  = grant_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BURST;
                    gid_d   = winner;
                    beats_d = '0;
                    grant_d = NREQ'(1) << winner;
`ifdef FIFO_ARB_PRIO0_EN
                    // Grants to the priority requester leave the rotation where it was.
                    if (winner != '0)
                        rr_ptr_d = next_ptr;
`else
                    rr_ptr_d = next_ptr;
`endif
                end
            end
            BURST: begin
                if (wr_en)
                    beats_d = beats_q + 1'b1;
                if (burst_end) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == BURST);
        wr_en     = 1'b0;
        if (state_q == BURST)
            wr_en = req[gid_q] & ~w_full;
        ack       = grant_q & {NREQ{wr_en}};
        wr_data   = wr_en ? req_data[gid_q*W +: W] : '0;
        // A request drop wins over a stall, so a full FIFO never pins a vanished owner.
        burst_end = ~req[gid_q] | (wr_en & (beats_q == BW'(MAX_BURST-1)));
    end

    assign grant = grant_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: per-cycle model comparison plus literal beat/grant traces.
module tb_fifo_write_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int MB   = 4;
`ifdef FIFO_ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    logic              write_clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_data;
    logic              w_full;
    logic [NREQ-1:0]   grant, ack;
    logic              wr_en;
    logic [W-1:0]      wr_data;
    logic              busy;

    int vectors = 0;
    int miscompares = 0;

    int rem[NREQ];
    int dat[NREQ];
    int g_log[$], w_log[$], b_own[$], b_dat[$];
    int eg[$], ew[$], eo[$], ed[$];

    int m_owner, m_beats, m_rr;

    always #5 write_clk = ~write_clk;

    fifo_write_arbiter #(.NREQ(NREQ), .W(W), .MAX_BURST(MB)) dut (
        .write_clk(write_clk), .reset(reset), .req(req), .req_data(req_data),
        .w_full(w_full), .grant(grant), .ack(ack), .wr_en(wr_en),
        .wr_data(wr_data), .busy(busy)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_q(input string nm, input int got[$], input int exp[$]);
        check({nm, "_len"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s[%0d]", nm, i), 64'(got[i]), 64'(exp[i]));
    endtask

    // Reference: arbitration winner from the request set and the rotation pointer.
    function automatic int pick(input logic [NREQ-1:0] r, input int rr);
        if (PRIO0 && r[0]) return 0;
        for (int k = 0; k < NREQ; k++)
            if (r[(rr + k) % NREQ]) return (rr + k) % NREQ;
        return -1;
    endfunction

    always @(posedge write_clk or posedge reset) begin
        if (reset) begin
            m_owner <= -1;
            m_beats <= 0;
            m_rr    <= 0;
        end else if (m_owner < 0) begin
            if (req != '0) begin
                m_owner <= pick(req, m_rr);
                m_beats <= 0;
                if (!PRIO0 || pick(req, m_rr) != 0)
                    m_rr <= (pick(req, m_rr) + 1) % NREQ;
            end
        end else begin
            if (req[m_owner] && !w_full)
                m_beats <= m_beats + 1;
            if (!req[m_owner] || (!w_full && m_beats + 1 == MB))
                m_owner <= -1;
        end
    end

    function automatic logic [63:0] e_wr();
        return (m_owner >= 0 && req[m_owner] && !w_full) ? 64'd1 : 64'd0;
    endfunction
    function automatic logic [63:0] e_grant();
        return (m_owner >= 0) ? (64'd1 << m_owner) : 64'd0;
    endfunction
    function automatic logic [63:0] e_data();
        return (e_wr() != 0) ? 64'(req_data[m_owner*W +: W]) : 64'd0;
    endfunction

    function automatic int idx_of(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(negedge write_clk) begin
        check("grant", 64'(grant), e_grant());
        check("busy", 64'(busy), (m_owner >= 0) ? 64'd1 : 64'd0);
        check("wr_en", 64'(wr_en), e_wr());
        check("ack", 64'(ack), (e_wr() != 0) ? e_grant() : 64'd0);
        check("wr_data", 64'(wr_data), e_data());
        g_log.push_back(int'(grant));
        w_log.push_back(int'(wr_en));
        if (wr_en) begin
            b_own.push_back(idx_of(ack));
            b_dat.push_back(int'(wr_data));
        end
    end

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req[i] = (rem[i] > 0);
            req_data[i*W +: W] = W'(dat[i]);
        end
    endtask

    // One cycle: producers advance on beats acked in the cycle just ending.
    task automatic tick();
        logic [NREQ-1:0] a;
        @(negedge write_clk);
        a = ack;
        @(posedge write_clk);
        #1;
        for (int i = 0; i < NREQ; i++)
            if (a[i]) begin
                rem[i]--;
                dat[i]++;
            end
        drive();
    endtask

    task automatic clear_logs();
        g_log.delete(); w_log.delete(); b_own.delete(); b_dat.delete();
    endtask

    task automatic do_reset();
        @(posedge write_clk);
        #1;
        reset  = 1'b1;
        w_full = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 0;
            dat[i] = 0;
        end
        drive();
        @(posedge write_clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        w_full = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 0;
            dat[i] = 0;
        end
        drive();
        #1;
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);

        // 1: one long request split into 4 + 2 beats with one bubble
        do_reset();
        rem[1] = 6; dat[1] = 'h10; drive(); clear_logs();
        repeat (10) tick();
        eg = '{0, 2, 2, 2, 2, 0, 2, 2, 2, 0};
        ew = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
        ed = '{'h10, 'h11, 'h12, 'h13, 'h14, 'h15};
        check_q("t1_grant", g_log, eg);
        check_q("t1_wr", w_log, ew);
        check_q("t1_data", b_dat, ed);

        // 2: all requesters continuous from reset
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 1000; dat[i] = 16 * i;
        end
        drive(); clear_logs();
        repeat (26) tick();
        eo = '{0,0,0,0, 1,1,1,1, 2,2,2,2, 3,3,3,3, 0,0,0,0};
        ed = '{0,1,2,3, 16,17,18,19, 32,33,34,35, 48,49,50,51, 4,5,6,7};
        eg.delete();
        for (int c = 0; c < 26; c++)
            eg.push_back((c % 5 == 0) ? 0 : (1 << eo[((c - 1) / 5) * 4]));
        check_q("t2_owner", b_own, eo);
        check_q("t2_data", b_dat, ed);
        check_q("t2_grant", g_log, eg);

        // 3: FIFO full for three cycles after beat 2
        do_reset();
        rem[2] = 4; dat[2] = 'h20; drive(); clear_logs();
        repeat (3) tick();
        w_full = 1'b1;
        repeat (3) tick();
        w_full = 1'b0;
        repeat (3) tick();
        eg = '{0, 4, 4, 4, 4, 4, 4, 4, 0};
        ew = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
        ed = '{'h20, 'h21, 'h22, 'h23};
        check_q("t3_grant", g_log, eg);
        check_q("t3_wr", w_log, ew);
        check_q("t3_data", b_dat, ed);

        // 4: asynchronous reset during beat 2 of requester 3
        do_reset();
        rem[3] = 4; dat[3] = 'h30; drive();
        tick(); tick();
        #1;
        check("t4_pre_wr", 64'(wr_en), 64'd1);
        check("t4_pre_grant", 64'(grant), 64'h8);
        check("t4_pre_data", 64'(wr_data), 64'h31);
        reset = 1'b1;
        #1;
        check("t4_rst_wr", 64'(wr_en), 64'd0);
        check("t4_rst_ack", 64'(ack), 64'd0);
        check("t4_rst_grant", 64'(grant), 64'd0);
        check("t4_rst_data", 64'(wr_data), 64'd0);
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 1000; dat[i] = 16 * i;
        end
        drive();
        @(posedge write_clk);
        #1;
        reset = 1'b0; clear_logs();
        repeat (3) tick();
        eg = '{0, 1, 1};
        eo = '{0, 0};
        check_q("t4_grant", g_log, eg);
        check_q("t4_owner", b_own, eo);

        // 5: owner drops after two beats while requester 0 waits
        do_reset();
        rem[1] = 1; dat[1] = 'h10; drive();
        repeat (4) tick();
        rem[0] = 1000; dat[0] = 0; rem[2] = 2; dat[2] = 'h20; drive(); clear_logs();
        repeat (7) tick();
        eg = '{0, 4, 4, 4, 0, 1, 1};
        ew = '{0, 1, 1, 0, 0, 1, 1};
        eo = '{2, 2, 0, 0};
        ed = '{'h20, 'h21, 0, 1};
        check_q("t5_grant", g_log, eg);
        check_q("t5_wr", w_log, ew);
        check_q("t5_owner", b_own, eo);
        check_q("t5_data", b_dat, ed);

        // 6: requesters 0 and 2 continuous
        do_reset();
        rem[0] = 1000; dat[0] = 0; rem[2] = 1000; dat[2] = 'h20; drive(); clear_logs();
        repeat (21) tick();
        eo.delete();
        for (int k = 0; k < 16; k++)
            eo.push_back(PRIO0 ? 0 : (((k / 4) % 2 == 1) ? 2 : 0));
        check_q("t6_owner", b_own, eo);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
